// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with programmable signed taps, line buffers and a
// two-stage elastic pipeline. Define CONV3X3_ABS_EN to output |sum| instead of sum.
module conv3x3_stream #(
  parameter int WIDTH_P  = 8,
  parameter int LINE_W_P = 16,
  parameter int LINES_P  = 16,
  parameter int COEF_W_P = 4,
  parameter int OUT_W_P  = WIDTH_P + COEF_W_P + 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WIDTH_P-1:0]    data_i,
  input  logic [9*COEF_W_P-1:0] coef_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OUT_W_P-1:0]    data_o,
  output logic                  eol_o,
  output logic                  eof_o
);

  localparam int COL_W  = (LINE_W_P > 1) ? $clog2(LINE_W_P) : 1;
  localparam int ROW_W  = (LINES_P > 1) ? $clog2(LINES_P) : 1;
  localparam int PROD_W = WIDTH_P + 1 + COEF_W_P;

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [9*COEF_W_P-1:0] coef_q;
  logic [WIDTH_P-1:0]    lb1_mem [LINE_W_P];
  logic [WIDTH_P-1:0]    lb2_mem [LINE_W_P];
  logic [WIDTH_P-1:0]    lb1_out, lb2_out;
  logic [WIDTH_P-1:0]    win_q [9];
  logic                  w_vld_q, w_eol_q, w_eof_q;
  logic                  valid_q, eol_q, eof_q;
  logic [OUT_W_P-1:0]    data_q;

  logic o_en, w_en, accept, interior, col_last, row_last;

  assign o_en     = !valid_q | ready_i;
  assign w_en     = !w_vld_q | o_en;
  assign ready_o  = w_en & !rst_i;
  assign accept   = valid_i & ready_o;
  assign col_last = (col_q == COL_W'(LINE_W_P - 1));
  assign row_last = (row_q == ROW_W'(LINES_P - 1));
  assign interior = (col_q >= COL_W'(2)) && (row_q >= ROW_W'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q  <= '0;
      row_q  <= '0;
      coef_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept && (col_q == '0) && (row_q == '0)) begin
        coef_q <= coef_i;
      end
    end
  end

  // Circular line buffers addressed by column: each slot holds the pixel
  // from the same column one (lb1) or two (lb2) lines earlier.
  assign lb1_out = lb1_mem[col_q];
  assign lb2_out = lb2_mem[col_q];

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1_mem[col_q] <= data_i;
      lb2_mem[col_q] <= lb1_out;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
      w_vld_q <= 1'b0;
      w_eol_q <= 1'b0;
      w_eof_q <= 1'b0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[3*r]   <= win_q[3*r+1];
        win_q[3*r+1] <= win_q[3*r+2];
      end
      win_q[2] <= lb2_out;
      win_q[5] <= lb1_out;
      win_q[8] <= data_i;
      w_vld_q  <= interior;
      w_eol_q  <= col_last;
      w_eof_q  <= col_last & row_last;
    end else if (w_en) begin
      w_vld_q <= 1'b0;
    end
  end

  // Products are sized so no tap can overflow; the wider tree absorbs the sum of nine.
  logic signed [PROD_W-1:0]  px, cf, prod;
  logic signed [OUT_W_P-1:0] sum;
  logic [OUT_W_P-1:0]        res;

  always_comb begin
    sum  = '0;
    px   = '0;
    cf   = '0;
    prod = '0;
    for (int k = 0; k < 9; k++) begin
      px   = {{COEF_W_P{1'b0}}, 1'b0, win_q[k]};
      cf   = {{(WIDTH_P+1){coef_q[k*COEF_W_P+COEF_W_P-1]}}, coef_q[k*COEF_W_P +: COEF_W_P]};
      prod = px * cf;
      sum  = sum + {{(OUT_W_P-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  always_comb begin
    res = sum;
`ifdef CONV3X3_ABS_EN
    if (sum[OUT_W_P-1]) begin
      res = -sum;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else if (o_en) begin
      valid_q <= w_vld_q;
      data_q  <= res;
      eol_q   <= w_eol_q;
      eof_q   <= w_eof_q;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign eol_o   = eol_q;
  assign eof_o   = eof_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream on a 4x4 frame: table-driven frames
// plus hand-written coefficient-timing and mid-frame reset sequences.
module tb_conv3x3_stream;

  localparam int W  = 8;
  localparam int LW = 4;
  localparam int LN = 4;
  localparam int CW = 4;
  localparam int OW = W + CW + 5;

  localparam int M_CONST  = 0;
  localparam int M_COL    = 1;
  localparam int M_ROW    = 2;
  localparam int M_INVROW = 3;

`ifdef CONV3X3_ABS_EN
  localparam int NEG80 = 80;
`else
  localparam int NEG80 = -80;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          valid_i, ready_o, valid_o, ready_i, eol_o, eof_o;
  logic [W-1:0]  data_i;
  logic [9*CW-1:0] coef_i;
  logic [OW-1:0] data_o;

  always #5 clk = ~clk;

  conv3x3_stream #(
    .WIDTH_P (W),
    .LINE_W_P(LW),
    .LINES_P (LN),
    .COEF_W_P(CW)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .coef_i (coef_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
    .eol_o  (eol_o),
    .eof_o  (eof_o)
  );

  typedef struct {
    logic [OW-1:0] d;
    logic          eol;
    logic          eof;
  } outRec_t;

  typedef struct {
    string       name;
    int          mode;
    int          cval;
    logic [35:0] coef;
    int          expVal;
    bit          gaps;
    bit          stall;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acceptCnt = 0;
  int firstValidCyc = -1;
  outRec_t outQ[$];

  logic          pend = 1'b0;
  outRec_t       pendRec;
  logic          stallPrev = 1'b0;
  outRec_t       heldRec;

  logic [35:0] GX, GY, ONES;
  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Transfers are recorded only if the handshake seen at negedge completes on the next edge.
  always @(negedge clk) begin
    if (valid_o && firstValidCyc < 0) firstValidCyc = cyc;
    if (stallPrev && valid_o) begin
      checkOutput("stallHoldData", data_o, heldRec.d);
      checkOutput("stallHoldEol", OW'(eol_o), OW'(heldRec.eol));
      checkOutput("stallHoldEof", OW'(eof_o), OW'(heldRec.eof));
    end
    stallPrev = valid_o & !ready_i;
    heldRec.d = data_o; heldRec.eol = eol_o; heldRec.eof = eof_o;
    pend = valid_o & ready_i;
    pendRec.d = data_o; pendRec.eol = eol_o; pendRec.eof = eof_o;
  end

  always @(posedge clk) begin
    cyc++;
    if (pend && !rst_i) outQ.push_back(pendRec);
    pend = 1'b0;
  end

  function automatic logic [35:0] packCoef(input int t0, input int t1, input int t2,
                                            input int t3, input int t4, input int t5,
                                            input int t6, input int t7, input int t8);
    logic [35:0] v;
    int t[9];
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3; t[4] = t4;
    t[5] = t5; t[6] = t6; t[7] = t7; t[8] = t8;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*4 +: 4] = 4'(t[k]);
    return v;
  endfunction

  function automatic vec_t mkVec(input string n, input int m, input int cv, input logic [35:0] cf,
                                 input int e, input bit g, input bit s);
    vec_t v;
    v.name = n; v.mode = m; v.cval = cv; v.coef = cf; v.expVal = e; v.gaps = g; v.stall = s;
    return v;
  endfunction

  function automatic logic [W-1:0] pixVal(input int mode, input int cval, input int r, input int c);
    case (mode)
      M_CONST: return W'(cval);
      M_COL:   return W'(10 * c);
      M_ROW:   return W'(10 * r);
      default: return W'(30 - 10 * r);
    endcase
  endfunction

  task automatic applyStimulus(input logic [W-1:0] px, output int hsCyc);
    logic rdy;
    int   c;
    int   t;
    bit   done;
    valid_i = 1'b1;
    data_i  = px;
    hsCyc   = -1;
    t       = 0;
    done    = 1'b0;
    while (!done && t < 200) begin
      @(negedge clk);
      rdy = ready_o;
      c   = cyc;
      @(posedge clk);
      #1;
      if (rdy) begin
        hsCyc = c;
        acceptCnt++;
        done = 1'b1;
      end
      t++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: got no accept in %0d cycles, required accept", t);
    end
  endtask

  task automatic sendFrame(input int mode, input int cval, input bit gaps, input bit switchCoef,
                           output int hs22);
    int h;
    hs22 = -1;
    for (int r = 0; r < LN; r++) begin
      for (int c = 0; c < LW; c++) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          valid_i = 1'b0;
          @(posedge clk);
          #1;
        end
        if (switchCoef && r == 1 && c == 3) coef_i = ONES;
        applyStimulus(pixVal(mode, cval, r, c), h);
        if (r == 2 && c == 2) hs22 = h;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic drainExpect(input string name, input int n);
    int t;
    t = 0;
    while (outQ.size() < n && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    checkOutput({name, "_count"}, OW'(outQ.size()), OW'(n));
  endtask

  task automatic checkFrameOutputs(input string name, input int n, input int firstVal, input int secondVal);
    outRec_t rec;
    int      e;
    for (int i = 0; i < n && outQ.size() > 0; i++) begin
      rec = outQ.pop_front();
      e = (i < 4) ? firstVal : secondVal;
      checkOutput($sformatf("%s_data%0d", name, i), rec.d, OW'(e));
      checkOutput($sformatf("%s_eol%0d", name, i), OW'(rec.eol), OW'((i % 2) == 1));
      checkOutput($sformatf("%s_eof%0d", name, i), OW'(rec.eof), OW'((i % 4) == 3));
    end
    outQ.delete();
  endtask

  initial begin
    int hs22;
    int base;

    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    coef_i  = '0;

    GX   = packCoef(-1, 0, 1, -2, 0, 2, -1, 0, 1);
    GY   = packCoef(-1, -2, -1, 0, 0, 0, 1, 2, 1);
    ONES = packCoef(1, 1, 1, 1, 1, 1, 1, 1, 1);

    vecs[0] = mkVec("ones",      M_CONST,  1, ONES, 9,     1'b0, 1'b0);
    vecs[1] = mkVec("gxCol",     M_COL,    0, GX,   80,    1'b0, 1'b0);
    vecs[2] = mkVec("gxRow",     M_ROW,    0, GX,   0,     1'b0, 1'b0);
    vecs[3] = mkVec("gyRow",     M_ROW,    0, GY,   80,    1'b0, 1'b0);
    vecs[4] = mkVec("gyInvRow",  M_INVROW, 0, GY,   NEG80, 1'b0, 1'b0);
    vecs[5] = mkVec("gxStall",   M_COL,    0, GX,   80,    1'b0, 1'b1);
    vecs[6] = mkVec("onesGaps",  M_CONST,  1, ONES, 9,     1'b1, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", OW'(valid_o), '0);
    checkOutput("rstData", data_o, '0);
    checkOutput("rstEol", OW'(eol_o), '0);
    checkOutput("rstEof", OW'(eof_o), '0);
    checkOutput("rstReady", OW'(ready_o), '0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      coef_i = vecs[v].coef;
      ready_i = 1'b1;
      outQ.delete();
      firstValidCyc = -1;
      base = acceptCnt;
      fork
        sendFrame(vecs[v].mode, vecs[v].cval, vecs[v].gaps, 1'b0, hs22);
        begin
          if (vecs[v].stall) begin
            int t;
            t = 0;
            while (acceptCnt < base + 11 && t < 300) begin
              @(posedge clk);
              t++;
            end
            #2 ready_i = 1'b0;
            repeat (4) @(posedge clk);
            @(negedge clk);
            checkOutput("stallReadyLow", OW'(ready_o), '0);
            checkOutput("stallValidHigh", OW'(valid_o), OW'(1));
            @(posedge clk);
            #2 ready_i = 1'b1;
          end
        end
      join
      if (v == 0) checkOutput("latency", OW'(firstValidCyc - hs22), OW'(2));
      drainExpect(vecs[v].name, 4);
      checkFrameOutputs(vecs[v].name, 4, vecs[v].expVal, vecs[v].expVal);
      @(posedge clk);
      #1;
    end

    // Coefficients latch only at pixel (0,0): a mid-frame change waits for the next frame.
    outQ.delete();
    coef_i = GX;
    sendFrame(M_COL, 0, 1'b0, 1'b1, hs22);
    sendFrame(M_CONST, 2, 1'b0, 1'b0, hs22);
    drainExpect("coefTiming", 8);
    checkFrameOutputs("coefTiming", 8, 80, 18);
    @(posedge clk);
    #1;

    outQ.delete();
    coef_i = ONES;
    for (int i = 0; i < 12; i++) applyStimulus(W'(1), hs22);
    rst_i   = 1'b1;
    valid_i = 1'b0;
    #1;
    checkOutput("midRstValid", OW'(valid_o), '0);
    checkOutput("midRstReady", OW'(ready_o), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    sendFrame(M_CONST, 1, 1'b0, 1'b0, hs22);
    drainExpect("afterRst", 4);
    checkFrameOutputs("afterRst", 4, 9, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
Streaming 3x3 convolution engine with runtime-programmable signed coefficients, for Sobel Gx/Gy and general 3x3 filtering. It consumes raster-order unsigned pixels over valid/ready and builds the window from two line buffers plus a 3x3 register array. It emits one signed result per interior pixel, with end-of-line and end-of-frame flags. It sits between the pixel source and the gradient-magnitude stage, and replaces the fixed box-sum window.

Parameters:
WIDTH_P, 8, pixel width (unsigned)
LINE_W_P, 16, pixels per line (>=3)
LINES_P, 16, lines per frame (>=3)
COEF_W_P, 4, signed coefficient width
OUT_W_P, WIDTH_P+COEF_W_P+5, result width, signed; treat as derived, do not override

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
valid_i  in  1  input pixel valid
ready_o  out  1  input accepted when valid_i & ready_o
data_i  in  WIDTH_P  pixel, unsigned
coef_i  in  9*COEF_W_P  signed taps; tap k is at bits [k*COEF_W_P +: COEF_W_P], with k = 3*r + c
valid_o  out  1  result valid
ready_i  in  1  downstream ready
data_o  out  OUT_W_P  convolution result
eol_o  out  1  result is the last interior output of its line
eof_o  out  1  result is the last output of the frame

Interface rule: one clock (clk_i); reset rst_i is asynchronous and active-high.

Behaviour:
- Reset, asynchronous: valid_o=0, data_o=0, eol_o=0, eof_o=0, col/row counters=0, window-stage valid=0, coefficient register=0. ready_o=0 while rst_i is high.
- Line-buffer RAM is not reset. Stale contents never reach valid outputs.
- Counters: col 0..LINE_W_P-1 and row 0..LINES_P-1 advance on each accept. col wraps to 0 and increments row; row wraps to 0 at the end of the frame.
- Window: w[r][c] holds pixel (row-2+r, col-2+c) of the accepted pixel, where r=0 is the top row and c=0 is the leftmost column.
  - On accept, the window shifts left and the right column loads {lb2_out, lb1_out, data_i}.
  - lb1 and lb2 each delay by exactly LINE_W_P accepts.
- Interior: an accepted pixel with row>=2 and col>=2 produces an output. Each frame produces exactly (LINE_W_P-2)*(LINES_P-2) outputs.
- Pipeline, two elastic stages: W (window + w_vld) and O (output regs).
  - o_en = !valid_o | ready_i
  - w_en = !w_vld | o_en
  - ready_o = w_en
  - On accept: w_vld <= interior.
  - On w_en without accept: w_vld <= 0.
  - On o_en: valid_o <= w_vld, and data_o, eol_o, eof_o are loaded.
- Latency: the accept edge plus 2 edges to valid_o (1 edge for the window, 1 for the output register). Throughput is 1 result/cycle with no bubbles when ready_i=1.
- Arithmetic:
  - sum = SUM over k of zext(pixel_k) * coef_k, signed.
  - Each product is WIDTH_P+1+COEF_W_P bits; the adder tree is OUT_W_P bits, so overflow is impossible.
  - Fully combinational between W and O.
- Coefficients: coef_i is latched into the coefficient register on acceptance of pixel (0,0).
  - The window still in stage W on that edge uses the old coefficients.
  - Changes to coef_i mid-frame have no effect until the next frame.
- eol_o=1 for the output with col=LINE_W_P-1. eof_o=1 for the output with col=LINE_W_P-1 and row=LINES_P-1.
- Stall: while valid_o & !ready_i, data_o, eol_o and eof_o hold stable. No drop and no duplicate.
- valid_i toggling: gaps insert bubbles only. Counters advance on accept only.
- Reset mid-frame: all in-flight data is discarded, and the next accepted pixel is (0,0).

Optional Feature:
CONV3X3_ABS_EN
- Defined: data_o = |sum| as an unsigned OUT_W_P-bit value (the most negative sum fits unsigned). The absolute value is taken in the O stage, with latency unchanged.
- Undefined: data_o is the two's-complement signed sum.

Test Plan:
All tests use LINE_W_P=4, LINES_P=4 (4 outputs/frame).
1. All pixels=1, coef all 1, ready_i=1, continuous valid -> outputs 9,9,9,9; eol_o on outputs 2 and 4; eof_o on output 4; first valid_o 2 cycles after accepting pixel (2,2).
2. Sobel Gx coef {-1,0,1,-2,0,2,-1,0,1}, pixel=10*col -> all outputs +80. Pixel=10*row -> all outputs 0.
3. Gy coef {-1,-2,-1,0,0,0,1,2,1}, pixel=10*row -> all outputs +80. With pixel=30-10*row -> -80 (data_o=-80 signed), or 80 when CONV3X3_ABS_EN is defined.
4. Backpressure: ready_i=0 for 5 cycles mid-frame and random valid_i gaps -> ready_o falls once W and O are full; output sequence and flags identical to test 1/2.
5. Coefficient timing: frame 1 with Gx, coef_i switched to all-1 at pixel (1,3), frame 2 all pixels=2 -> frame 1 all Gx results; frame 2 outputs all 18.
6. Reset mid-frame: assert rst_i at pixel (2,3) -> valid_o=0 immediately, no spurious output; the next full frame gives test-1 results.
